// File: rtl/delay_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : delay_arbiter_if
// Brief   : Requester and shared-counter signal bundle for delay_arbiter.
// Revision: 1.0
// ============================================================================
interface delay_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]       i_req;
   logic [NUM_REQ*WIDTH-1:0] i_top;
   logic [NUM_REQ-1:0]       o_grant;
   logic [NUM_REQ-1:0]       o_done;
   logic                     o_busy;
   logic                     o_cnt_reset;
   logic                     o_cnt_enabled;
   logic [WIDTH-1:0]         o_cnt_top;
   logic                     i_cnt_hit_top;

   // Environment side: requesters plus the shared counter.
   modport master (
      output i_req, i_top, i_cnt_hit_top,
      input  o_grant, o_done, o_busy, o_cnt_reset, o_cnt_enabled, o_cnt_top
   );

   // Arbiter side.
   modport slave (
      input  i_req, i_top, i_cnt_hit_top,
      output o_grant, o_done, o_busy, o_cnt_reset, o_cnt_enabled, o_cnt_top
   );
endinterface
`default_nettype wire

// File: rtl/delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : delay_arbiter
// Brief   : Round-robin owner of one shared counter; pulses done per requester.
// Revision: 1.0
// ============================================================================
module delay_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
) (
   input  wire logic       i_clk,
   input  wire logic       i_reset,
   delay_arbiter_if.slave  bus
);
   localparam int c_IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOAD = 2'd1;
   localparam logic [1:0] c_RUN  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]         r_state;
   logic [c_IDX_W-1:0] r_owner;
   logic [c_IDX_W-1:0] r_last_owner;
   logic [WIDTH-1:0]   r_cnt_top;

   logic [c_IDX_W-1:0] w_winner;
   logic               w_found;
   logic               w_owner_req;
   logic [NUM_REQ-1:0] w_owner_hot;

   // Search starts just past the previous owner so every requester gets a turn.
   always_comb begin
      w_winner = r_last_owner;
      w_found  = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         if (!w_found && bus.i_req[(int'(r_last_owner) + off) % NUM_REQ]) begin
            w_winner = c_IDX_W'((int'(r_last_owner) + off) % NUM_REQ);
            w_found  = 1'b1;
         end
      end
   end

   assign w_owner_req = bus.i_req[r_owner];
   assign w_owner_hot = NUM_REQ'(1) << r_owner;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= c_IDLE;
         r_owner      <= '0;
         r_last_owner <= c_IDX_W'(NUM_REQ - 1);
         r_cnt_top    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_found) begin
                  r_owner   <= w_winner;
                  r_cnt_top <= bus.i_top[int'(w_winner)*WIDTH +: WIDTH];
                  r_state   <= c_LOAD;
               end
            end
            c_LOAD: begin
               if (!w_owner_req) begin
                  r_last_owner <= r_owner;
                  r_state      <= c_IDLE;
               end else begin
                  r_state <= c_RUN;
               end
            end
            c_RUN: begin
               // A withdrawn request wins over a coincident hit: no done pulse.
               if (!w_owner_req) begin
                  r_last_owner <= r_owner;
                  r_state      <= c_IDLE;
               end else if (bus.i_cnt_hit_top) begin
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               r_last_owner <= r_owner;
               r_state      <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.o_busy        = (r_state != c_IDLE);
   assign bus.o_grant       = bus.o_busy ? w_owner_hot : '0;
   assign bus.o_done        = (r_state == c_DONE) ? w_owner_hot : '0;
   assign bus.o_cnt_reset   = (r_state != c_RUN);
   assign bus.o_cnt_enabled = (r_state == c_LOAD) || (r_state == c_RUN);
   assign bus.o_cnt_top     = r_cnt_top;
endmodule
`default_nettype wire

// File: tb/tb_delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_delay_arbiter
// Brief   : Directed and randomized checks of delay_arbiter against a
//           transaction-timeline model and a model of the shared counter.
// Revision: 1.0
// ============================================================================
module tb_delay_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   delay_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   delay_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   // Shared counter: clears when reset+enabled, counts when enabled.
   logic [W-1:0] cnt_value = '0;
   always @(posedge clk) begin
      if (bus.o_cnt_enabled) cnt_value <= bus.o_cnt_reset ? '0 : cnt_value + 1'b1;
   end
   assign bus.i_cnt_hit_top = (cnt_value == bus.o_cnt_top);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a grant is a timeline of age 1 (load), 2..T+2 (counting), T+3 (done).
   bit           m_active;
   int           m_owner;
   int           m_last;
   int           m_age;
   logic [W-1:0] m_top;
   int           m_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_owner  = 0;
         m_last   = N - 1;
         m_age    = 0;
         m_top    = '0;
      end else if (m_active) begin
         if (m_age == int'(m_top) + 3) begin
            m_active = 1'b0;
            m_last   = m_owner;
         end else if (!bus.i_req[m_owner]) begin
            m_active = 1'b0;
            m_last   = m_owner;
         end else begin
            m_age++;
         end
      end else begin
         for (int o = 1; o <= N; o++) begin
            m_idx = (m_last + o) % N;
            if (!m_active && bus.i_req[m_idx]) begin
               m_active = 1'b1;
               m_owner  = m_idx;
               m_age    = 1;
               m_top    = bus.i_top[m_idx*W +: W];
            end
         end
      end
   end

   always @(posedge clk) begin
      int t;
      logic [N-1:0] hot;
      #1;
      t   = int'(m_top);
      hot = m_active ? (N'(1) << m_owner) : '0;
      check("grant",   32'(bus.o_grant), 32'(hot));
      check("done",    32'(bus.o_done), (m_active && m_age == t + 3) ? 32'(hot) : 32'd0);
      check("busy",    32'(bus.o_busy), 32'(m_active));
      check("cnt_en",  32'(bus.o_cnt_enabled), 32'(m_active && m_age <= t + 2));
      check("cnt_rst", 32'(bus.o_cnt_reset), 32'(!(m_active && m_age >= 2 && m_age <= t + 2)));
      check("cnt_top", 32'(bus.o_cnt_top), 32'(m_top));
   end

   // Raise one request in IDLE, expect done after exp_lat cycles, then release.
   task automatic run_single(input int idx, input int top, input int exp_lat, input string nm);
      int lat;
      bus.i_top[idx*W +: W] = W'(top);
      bus.i_req[idx] = 1'b1;
      @(negedge clk);
      lat = 1;
      check({nm, "_grant"}, 32'(bus.o_grant), 32'(1) << idx);
      while (!bus.o_done[idx] && lat < 500) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, lat, exp_lat);
      bus.i_req[idx] = 1'b0;
      @(negedge clk);
      check({nm, "_busy_after"}, 32'(bus.o_busy), 0);
   endtask

   int exp_own [5] = '{0, 1, 2, 3, 0};

   initial begin
      int lat;
      bit saw_done3;
      bus.i_req = '0;
      bus.i_top = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_grant",  32'(bus.o_grant), 0);
      check("rst_busy",   32'(bus.o_busy), 0);
      check("rst_cntrst", 32'(bus.o_cnt_reset), 1);
      check("rst_cnten",  32'(bus.o_cnt_enabled), 0);
      check("rst_cnttop", 32'(bus.o_cnt_top), 0);
      rst = 1'b0;
      @(negedge clk);

      run_single(1, 5, 8, "single_top5");
      run_single(2, 0, 3, "top0");

      // i_top change during RUN is ignored.
      bus.i_top[0 +: W] = W'(8);
      bus.i_req[0] = 1'b1;
      lat = 0;
      repeat (4) begin @(negedge clk); lat++; end
      bus.i_top[0 +: W] = W'(3);
      while (!bus.o_done[0] && lat < 100) begin @(negedge clk); lat++; end
      check("topchg_latency", lat, 11);
      check("topchg_cnt_top", 32'(bus.o_cnt_top), 8);
      bus.i_req[0] = 1'b0;
      @(negedge clk);

      // All four continuously requesting from a fresh reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < N; n++) bus.i_top[n*W +: W] = W'(2);
      bus.i_req = '1;
      for (int k = 0; k < 5; k++) begin
         lat = 0;
         do begin @(negedge clk); lat++; end while (bus.o_done == '0 && lat < 50);
         check("rr_owner", 32'(bus.o_done), 32'(1) << exp_own[k]);
         check("rr_spacing", lat, (k == 0) ? 5 : 6);
      end
      bus.i_req = '0;
      @(negedge clk);
      check("rr_idle_after", 32'(bus.o_busy), 0);

      // Cancel of req3 in RUN hands the counter to a waiting req0.
      saw_done3 = 1'b0;
      bus.i_top[3*W +: W] = W'(100);
      bus.i_req[3] = 1'b1;
      @(negedge clk);
      lat = 1;
      bus.i_top[0 +: W] = W'(4);
      bus.i_req[0] = 1'b1;
      while (lat < 11) begin
         @(negedge clk);
         lat++;
         saw_done3 |= bus.o_done[3];
      end
      bus.i_req[3] = 1'b0;
      @(negedge clk);
      saw_done3 |= bus.o_done[3];
      check("cancel_busy", 32'(bus.o_busy), 0);
      check("cancel_nodone", 32'(saw_done3), 0);
      @(negedge clk);
      check("cancel_next_grant", 32'(bus.o_grant), 32'h1);
      lat = 1;
      while (!bus.o_done[0] && lat < 50) begin @(negedge clk); lat++; end
      check("cancel_req0_latency", lat, 7);
      bus.i_req[0] = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      bus.i_top[0 +: W] = W'(50);
      bus.i_req[0] = 1'b1;
      repeat (21) @(negedge clk);
      bus.i_top[1*W +: W] = W'(1);
      bus.i_req[1] = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("arst_grant",  32'(bus.o_grant), 0);
      check("arst_busy",   32'(bus.o_busy), 0);
      check("arst_done",   32'(bus.o_done), 0);
      check("arst_cntrst", 32'(bus.o_cnt_reset), 1);
      check("arst_cnten",  32'(bus.o_cnt_enabled), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("arst_next_grant", 32'(bus.o_grant), 32'h1);
      lat = 1;
      while (!bus.o_done[0] && lat < 100) begin @(negedge clk); lat++; end
      check("arst_req0_latency", lat, 53);
      bus.i_req[0] = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.o_done[1] && lat < 50);
      check("arst_req1_after", 32'(bus.o_done), 32'h2);
      bus.i_req[1] = 1'b0;
      @(negedge clk);

      // Randomized traffic: holds, withdrawals, re-requests, top churn, resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int n = 0; n < N; n++) begin
            if (bus.o_done[n]) begin
               if ($urandom_range(0, 3) != 0) bus.i_req[n] = 1'b0;
            end else if (!bus.i_req[n]) begin
               if ($urandom_range(0, 7) == 0) bus.i_req[n] = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
               bus.i_req[n] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) bus.i_top[n*W +: W] = W'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      bus.i_req = '0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/delay_arbiter.md
# delay_arbiter

Round-robin scheduler that shares one `counter` instance between up to NUM_REQ requesters that each need a timed delay, such as deal pacing, LED blink hold and bet timeout. The block grants the counter to one requester at a time and loads that requester's terminal count. It runs the counter until it reports hitting top, then pulses a per-requester done. It sits between the game FSMs and the single shared counter.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 16: counter width; must match the shared counter's WIDTH.
- i_clk  in  1: clock.
- i_reset  in  1: asynchronous, active-high reset.
- i_req  in  NUM_REQ: bit n high = requester n wants a delay; held until its o_done.
- i_top  in  NUM_REQ*WIDTH: requester n's terminal count is bits [n*WIDTH +: WIDTH].
- o_grant  out  NUM_REQ: one-hot owner of the counter; all zero when idle.
- o_done  out  NUM_REQ: one-cycle pulse to the owner when its delay has elapsed.
- o_busy  out  1: high in LOAD, RUN and DONE.
- o_cnt_reset  out  1: drives the counter's i_reset.
- o_cnt_enabled  out  1: drives the counter's i_enabled.
- o_cnt_top  out  WIDTH: drives the counter's i_top.
- i_cnt_hit_top  in  1: from the counter's o_hitTop.

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered state; all outputs decode from registered state, owner index and top.
- Counter contract relied on:
  - value clears while its reset is high and its enable is high.
  - value increments by 1 per enabled clock.
  - hitTop = (value == top).
- IDLE:
  - o_grant=0, o_cnt_reset=1, o_cnt_enabled=0.
  - If any i_req bit is set, pick the winner by round-robin, searching from last_owner+1 upward with wrap.
  - Latch the winner as owner and its i_top slice as o_cnt_top, then go to LOAD.
- LOAD, exactly 1 cycle:
  - o_grant[owner]=1, o_cnt_reset=1, o_cnt_enabled=1, so the counter clears to 0.
  - Go to RUN.
- RUN:
  - o_cnt_reset=0, o_cnt_enabled=1.
  - On i_cnt_hit_top=1, go to DONE.
- DONE, exactly 1 cycle:
  - o_done[owner]=1, o_cnt_enabled=0.
  - Set last_owner=owner, then go to IDLE.
- Cancel: if i_req[owner] falls while in LOAD or RUN:
  - go to IDLE next cycle with no o_done pulse;
  - last_owner is still updated to owner.
- o_cnt_top is latched only on IDLE→LOAD. Changes to i_top during LOAD, RUN or DONE are ignored.
- Multiple requests: at most one grant; non-winners wait and stay asserted.
- If a requester keeps i_req high after its o_done, that counts as a new request. Round-robin then favours the others.
- top=0: the counter shows value 0 = top in the first RUN cycle, so RUN lasts 1 cycle.
- top = all ones: legal; RUN lasts 2^WIDTH cycles.
- Reset (async, any state): takes effect immediately, without waiting for a clock edge.
  - state=IDLE, owner=0, last_owner=NUM_REQ-1 (requester 0 wins first).
  - o_grant=0, o_done=0, o_busy=0.
  - o_cnt_reset=1, o_cnt_enabled=0, o_cnt_top=0.
  - A delay in progress is dropped with no o_done.

## Timing
- i_req[n] is sampled high at edge k in IDLE:
  - LOAD during cycle k+1;
  - RUN during cycles k+2 .. k+2+T, with counter value 0..T;
  - DONE during cycle k+3+T (o_done[n] high);
  - IDLE during cycle k+4+T.
- Request-to-done latency is T+3 cycles.
- Minimum spacing between consecutive grants is T+4 cycles, since IDLE takes one cycle.
- o_grant rises at the start of LOAD and falls at the end of DONE. o_done coincides with the final grant cycle.
- A cancel seen at edge j (req low in LOAD or RUN) puts the block in IDLE in cycle j+1.

## Test plan
- Reset mid-RUN (req0, top=50, i_reset pulsed at RUN cycle 20) -> immediately o_grant=0, o_busy=0, o_cnt_reset=1, o_cnt_enabled=0; no o_done; next grant goes to req0.
- Single request (req1 only, top=5) -> o_grant=0010 from cycle k+1; o_done[1] exactly at k+8; o_busy low at k+9.
- All four requesting continuously, each with top=2 -> grants in order 0,1,2,3,0; each o_done exactly 5 cycles after its IDLE sample; grants 6 cycles apart.
- top=0 on req2 -> exactly one RUN cycle; o_done[2] at k+3.
- Cancel: req3 (top=100) drops at RUN cycle 10 -> IDLE next cycle, no o_done[3]; a pending req0 is granted from that IDLE.
- i_top[0] changed from 8 to 3 during RUN -> o_cnt_top stays 8; o_done[0] at k+11.
